bpredict_tagged: RTL and testbench



---
 rtl/bpredict_tagged.sv | 143 ++++++++++++++
 tb/tb_bpredict_tagged.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bpredict_tagged.sv
// Tagged direct-mapped branch target buffer with saturating direction counters
// and a sequential invalidation sweep that blocks lookups while it runs.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module bpredict_tagged #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 6,
  parameter int unsigned CTR_BITS   = 2
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  input  logic [`SIZE_ADDR-1:0] iw_pc,
  output logic                  ow_hit,
  output logic                  ow_taken,
  output logic [`SIZE_ADDR-1:0] ow_target,
  input  logic                  iw_update,
  input  logic [`SIZE_ADDR-1:0] iw_update_pc,
  input  logic                  iw_actual_taken,
  input  logic [`SIZE_ADDR-1:0] iw_actual_target,
  input  logic                  iw_flush,
  output logic                  ow_busy
);

  localparam int unsigned EntryNum = 2 ** INDEX_BITS;
  localparam int unsigned TagLo    = INDEX_BITS;
  localparam int unsigned TagHi    = INDEX_BITS + TAG_BITS - 1;

  localparam logic [CTR_BITS-1:0] CtrWeakT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CtrWeakNt = CtrWeakT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CtrMax    = '1;
  localparam logic [CTR_BITS-1:0] CtrMin    = '0;
  localparam logic [INDEX_BITS-1:0] PtrLast = INDEX_BITS'(EntryNum - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;

  logic                    valid_q [EntryNum];
  logic [TAG_BITS-1:0]     tag_q   [EntryNum];
  logic [`SIZE_ADDR-1:0]   tgt_q   [EntryNum];
  logic [CTR_BITS-1:0]     ctr_q   [EntryNum];

  logic [INDEX_BITS-1:0]   idx, uidx;
  logic [TAG_BITS-1:0]     ltag, utag;
  logic                    u_hit, upd_en, sweep_clr;
  logic [CTR_BITS-1:0]     ctr_nxt;
  logic                    unused_pc_bits;

  // FSM: state register
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM: next state; a flush during the sweep does not restart it
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (iw_flush) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (ptr_q == PtrLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ow_busy   = 1'b0;
    sweep_clr = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StSweep: begin
        ow_busy   = 1'b1;
        sweep_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // Lookup
  assign idx       = iw_pc[INDEX_BITS-1:0];
  assign ltag      = iw_pc[TagHi:TagLo];
  assign ow_hit    = valid_q[idx] && (tag_q[idx] == ltag) && !ow_busy;
  assign ow_taken  = ow_hit && ctr_q[idx][CTR_BITS-1];
  assign ow_target = ow_hit ? tgt_q[idx] : '0;

  // Update; a miss that resolved not-taken leaves the table alone
  assign uidx   = iw_update_pc[INDEX_BITS-1:0];
  assign utag   = iw_update_pc[TagHi:TagLo];
  assign u_hit  = valid_q[uidx] && (tag_q[uidx] == utag);
  assign upd_en = (state_q == StIdle) && iw_update && !iw_flush && (u_hit || iw_actual_taken);

  always_comb begin
    ctr_nxt = ctr_q[uidx];
    if (iw_actual_taken) begin
      if (ctr_q[uidx] != CtrMax) ctr_nxt = ctr_q[uidx] + CTR_BITS'(1);
    end else begin
      if (ctr_q[uidx] != CtrMin) ctr_nxt = ctr_q[uidx] - CTR_BITS'(1);
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < EntryNum; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CtrWeakNt;
      end
    end else if (sweep_clr) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (upd_en) begin
      if (u_hit) begin
        ctr_q[uidx] <= ctr_nxt;
        if (iw_actual_taken) tgt_q[uidx] <= iw_actual_target;
      end else begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        tgt_q[uidx]   <= iw_actual_target;
        ctr_q[uidx]   <= CtrWeakT;
      end
    end
  end

  assign unused_pc_bits = ^{iw_pc[`SIZE_ADDR-1:TagHi+1], iw_update_pc[`SIZE_ADDR-1:TagHi+1]};

endmodule

// File: tb/tb_bpredict_tagged.sv
// Scoreboard bench for bpredict_tagged: expectations are queued as stimulus is
// driven and compared against the outputs at the following falling edge.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module tb_bpredict_tagged;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [`SIZE_ADDR-1:0] pc, upd_pc, act_tgt, target;
  logic                  hit, taken, upd, act_taken, flush, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string                 tag;
    logic                  hit;
    logic                  taken;
    logic [`SIZE_ADDR-1:0] tgt;
    logic                  busy;
  } exp_t;

  exp_t exp_q[$];

  bpredict_tagged #(
    .INDEX_BITS(4),
    .TAG_BITS  (6),
    .CTR_BITS  (2)
  ) dut (
    .iw_clk          (clk),
    .iw_rst_n        (rst_n),
    .iw_pc           (pc),
    .ow_hit          (hit),
    .ow_taken        (taken),
    .ow_target       (target),
    .iw_update       (upd),
    .iw_update_pc    (upd_pc),
    .iw_actual_taken (act_taken),
    .iw_actual_target(act_tgt),
    .iw_flush        (flush),
    .ow_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".hit"},    64'(hit),    64'(e.hit));
      check({e.tag, ".taken"},  64'(taken),  64'(e.taken));
      check({e.tag, ".target"}, 64'(target), 64'(e.tgt));
      check({e.tag, ".busy"},   64'(busy),   64'(e.busy));
    end
  end

  task automatic drive(input logic [31:0] lpc, input logic u, input logic [31:0] upc,
                       input logic at, input logic [31:0] atgt, input logic fl);
    pc        = lpc;
    upd       = u;
    upd_pc    = upc;
    act_taken = at;
    act_tgt   = atgt;
    flush     = fl;
  endtask

  task automatic expect_out(input string tag, input logic h, input logic t,
                            input logic [31:0] tg, input logic b);
    exp_t e;
    e.tag = tag; e.hit = h; e.taken = t; e.tgt = tg; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lookup-only cycle
  task automatic look(input string tag, input logic [31:0] lpc, input logic h, input logic t,
                      input logic [31:0] tg, input logic b);
    drive(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_out(tag, h, t, tg, b);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state
    look("reset", 32'h013, 1'b0, 1'b0, 32'h0, 1'b0);

    // 2: allocate; same-cycle lookup still sees the old entry
    drive(32'h013, 1'b1, 32'h013, 1'b1, 32'h200, 1'b0);
    expect_out("alloc_same", 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    look("alloc_next", 32'h013, 1'b1, 1'b1, 32'h200, 1'b0);

    // 3: counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10, target held on not-taken
    drive(32'h013, 1'b1, 32'h013, 1'b0, 32'h5A0, 1'b0);
    expect_out("ctr10", 1'b1, 1'b1, 32'h200, 1'b0);
    tick();
    drive(32'h013, 1'b1, 32'h013, 1'b0, 32'h5A0, 1'b0);
    expect_out("ctr01", 1'b1, 1'b0, 32'h200, 1'b0);
    tick();
    drive(32'h013, 1'b1, 32'h013, 1'b0, 32'h5A0, 1'b0);
    expect_out("ctr00a", 1'b1, 1'b0, 32'h200, 1'b0);
    tick();
    drive(32'h013, 1'b1, 32'h013, 1'b1, 32'h200, 1'b0);
    expect_out("ctr00b", 1'b1, 1'b0, 32'h200, 1'b0);
    tick();
    drive(32'h013, 1'b1, 32'h013, 1'b1, 32'h200, 1'b0);
    expect_out("ctr01b", 1'b1, 1'b0, 32'h200, 1'b0);
    tick();
    look("ctr10b", 32'h013, 1'b1, 1'b1, 32'h200, 1'b0);

    // 4: alias replacement, taken hit retargets, not-taken miss is inert
    drive(32'h013, 1'b1, 32'h023, 1'b1, 32'h300, 1'b0);
    expect_out("alias_same", 1'b1, 1'b1, 32'h200, 1'b0);
    tick();
    look("alias_old", 32'h013, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(32'h023, 1'b1, 32'h043, 1'b0, 32'h700, 1'b0);
    expect_out("alias_new", 1'b1, 1'b1, 32'h300, 1'b0);
    tick();
    drive(32'h023, 1'b1, 32'h023, 1'b1, 32'h340, 1'b0);
    expect_out("nt_miss_inert", 1'b1, 1'b1, 32'h300, 1'b0);
    tick();
    look("retarget", 32'h023, 1'b1, 1'b1, 32'h340, 1'b0);
    look("miss_043", 32'h043, 1'b0, 1'b0, 32'h0, 1'b0);

    // 5: fill, flush sweep, dropped updates, ignored re-flush
    for (int i = 0; i < 16; i++) begin
      drive(32'h0, 1'b1, 32'h100 | i, 1'b1, 32'h400 + 4 * i, 1'b0);
      tick();
    end
    for (int i = 0; i < 16; i++)
      look($sformatf("fill%0d", i), 32'h100 | i, 1'b1, 1'b1, 32'h400 + 4 * i, 1'b0);
    drive(32'h105, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    expect_out("flush_cyc", 1'b1, 1'b1, 32'h414, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(32'h10F, k == 5, 32'h1A7, 1'b1, 32'h777, k == 8);
      expect_out($sformatf("sweep%0d", k), 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    for (int i = 0; i < 16; i++)
      look($sformatf("post%0d", i), 32'h100 | i, 1'b0, 1'b0, 32'h0, 1'b0);
    look("drop_mid", 32'h1A7, 1'b0, 1'b0, 32'h0, 1'b0);

    // update + flush together: flush wins
    drive(32'h0, 1'b1, 32'h155, 1'b1, 32'h500, 1'b0);
    tick();
    drive(32'h155, 1'b1, 32'h166, 1'b1, 32'h600, 1'b1);
    expect_out("uf_same", 1'b1, 1'b1, 32'h500, 1'b0);
    tick();
    for (int k = 0; k < 16; k++)
      look($sformatf("uf_sweep%0d", k), 32'h166, 1'b0, 1'b0, 32'h0, 1'b1);
    look("uf_166", 32'h166, 1'b0, 1'b0, 32'h0, 1'b0);
    look("uf_155", 32'h155, 1'b0, 1'b0, 32'h0, 1'b0);

    // 6: reset in the middle of a sweep
    drive(32'h0, 1'b1, 32'h1A2, 1'b1, 32'h820, 1'b0);
    tick();
    drive(32'h1A2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    expect_out("r_pre", 1'b1, 1'b1, 32'h820, 1'b0);
    tick();
    for (int k = 0; k < 5; k++)
      look($sformatf("r_sweep%0d", k), 32'h1A2, 1'b0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    drive(32'h1A2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_out("r_async", 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    look("r_after", 32'h1A2, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(32'h1A2, 1'b1, 32'h1A2, 1'b1, 32'h820, 1'b0);
    expect_out("r_realloc_same", 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(32'h1A2, 1'b1, 32'h1A2, 1'b0, 32'h0, 1'b0);
    expect_out("r_weak_t", 1'b1, 1'b1, 32'h820, 1'b0);
    tick();
    look("r_weak_nt", 32'h1A2, 1'b1, 1'b0, 32'h820, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
